rsp_round_ctrl: RTL
===================

# rsp_round_ctrl

Round controller for the rock-scissors-paper game. It scans the 3x4 keypad and debounces the player's pick, samples a free-running computer pick, and judges each round. It keeps both scores and ends the match when either side reaches the win score. It sits between the keypad pins and the LED/display drivers.

## Interface
- TICK_DIV, 500: CLK cycles per scan/debounce tick (≥2).
- DEBOUNCE, 4: consecutive ticks a key must stay stable to be accepted (≥1).
- SHOW_TICKS, 200: ticks the round result is held before rescanning (≥1).
- WIN_SCORE, 3: score that ends the match (1..15).
- CLK  in  1  system clock, all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- key_row  in  4  keypad row returns; asynchronous, synchronized internally with 2 flops.
- start  in  1  begin or restart a match; sampled only in IDLE/DONE.
- key_col  out  3  one-hot column drive: 001 = rock, 010 = scissor, 100 = paper.
- user_sel  out  3  accepted player pick, one-hot (same coding as key_col).
- cpu_sel  out  3  computer pick, one-hot.
- result  out  2  00 none, 01 user wins, 10 cpu wins, 11 draw.
- result_valid  out  1  one-CLK pulse when result/scores update.
- user_score, cpu_score  out  4 each  match scores.
- match_over  out  1  high in DONE.
- match_winner  out  1  0 = user, 1 = cpu; valid when match_over.
- busy  out  1  high in every state except IDLE/DONE.

## Operation
- Reset values:
  - state IDLE; all outputs 0 (key_col 000).
  - tick counter 0; rand = 1.
- Tick:
  - Counter counts 0..TICK_DIV-1 and runs free from reset.
  - tick = 1 for the one CLK where count = TICK_DIV-1.
- rand: 2-bit counter, advances 1→2→3→1 every CLK regardless of state; never 0.
- Synchronized row value is called krow below.
- IDLE:
  - key_col = 000.
  - start=1 → SCAN, key_col = 001.
- SCAN, evaluated on tick:
  - krow = 0000: rotate key_col 001→010→100→001.
  - krow = 0001: latch the candidate column, clear the debounce count, go to DEBOUNCE.
  - Any other nonzero krow: hold key_col and stay in SCAN.
- DEBOUNCE:
  - key_col is held.
  - On tick with krow = 0001: count+1. When count reaches DEBOUNCE → accept.
  - On tick with krow ≠ 0001: return to SCAN, count cleared, no rotation on that tick.
- Accept (the same CLK edge):
  - user_sel = candidate column.
  - cpu_sel = one-hot(rand): 1→001, 2→010, 3→100.
  - → JUDGE.
- JUDGE (one CLK):
  - Rock beats scissor, scissor beats paper, paper beats rock; equal picks = draw.
  - Register result and increment the winner's score; a draw changes neither score.
  - result_valid = 1 for this cycle.
  - → SHOW.
- SHOW: hold all outputs for SHOW_TICKS ticks → WAIT_RELEASE.
- WAIT_RELEASE:
  - On the first tick with krow = 0000: if either score = WIN_SCORE → DONE, else → SCAN with key_col = 001.
  - result and the sels keep their values until the next JUDGE.
- DONE:
  - key_col = 000; match_over = 1.
  - match_winner = 1 iff cpu_score = WIN_SCORE.
  - start=1 → clear scores, sels, result and match_over; → SCAN with key_col = 001.
- start is ignored in SCAN..WAIT_RELEASE.
- Scores cannot exceed WIN_SCORE; both reaching it at once is impossible, since only one side increments per round.

## Timing
- start is sampled at edge N; state = SCAN and key_col = 001 from N+1.
- A key press reaches krow after 2 CLK, then waits for the next tick.
- Press to accept: at least DEBOUNCE+1 ticks (detect tick plus DEBOUNCE stable ticks) with a stable press.
- Accept edge A: sels valid from A+1. Edge A+1: result/scores valid from A+2, result_valid high A+1..A+2 (exactly one CLK).
- SHOW lasts SHOW_TICKS ticks measured from the tick after entry.
- RESET_N low at any time, including mid-debounce or mid-SHOW: immediate return to all reset values; no pulse is emitted. Release is synchronous to CLK.

## Test plan
Bench parameters: TICK_DIV=4, DEBOUNCE=2, SHOW_TICKS=2, WIN_SCORE=2.
- Reset then idle:
  - Stimulus: RESET_N low, then high, no start.
  - Required: key_col = 000, busy = 0, all scores 0, rand cycles 1,2,3 forever.
- Scan rotation:
  - Stimulus: start pulse, krow = 0000.
  - Required: key_col 001 → 010 (4 CLK) → 100 → 001, one step per tick.
- Debounced win:
  - Stimulus: hold 0001 while key_col = 001, with rand = 2 sampled at accept.
  - Required: user_sel = 001, cpu_sel = 010, result = 01, user_score = 1, one result_valid pulse.
- Bounce rejection:
  - Stimulus: 0001 for one tick, then 0000.
  - Required: return to SCAN, no result_valid, scores unchanged.
- Draw and match end:
  - Stimulus: a draw round (paper vs rand = 3), then two cpu wins.
  - Required: result = 11 with scores unchanged; after release, DONE with match_over = 1, match_winner = 1, cpu_score = 2; start clears to 0/0 in SCAN.
- Mid-round reset:
  - Stimulus: assert RESET_N during SHOW.
  - Required: all outputs go to 0 asynchronously; IDLE after release.

Source files
------------

// File: rtl/rsp_round_ctrl.sv
// Rock-scissors-paper round controller: keypad scan and debounce, computer pick,
// round judging, score keeping and match end detection.
module rsp_round_ctrl #(
  parameter int TICK_DIV   = 500,
  parameter int DEBOUNCE   = 4,
  parameter int SHOW_TICKS = 200,
  parameter int WIN_SCORE  = 3
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] key_row,
  input  logic       start,
  output logic [2:0] key_col,
  output logic [2:0] user_sel,
  output logic [2:0] cpu_sel,
  output logic [1:0] result,
  output logic       result_valid,
  output logic [3:0] user_score,
  output logic [3:0] cpu_score,
  output logic       match_over,
  output logic       match_winner,
  output logic       busy
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int SW = $clog2(SHOW_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);
  localparam logic [SW-1:0] SHOW_LAST = SW'(SHOW_TICKS - 1);
  localparam logic [3:0]    WIN       = 4'(WIN_SCORE);
  localparam logic [2:0]    COL_ROCK  = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_DEB, S_JUDGE, S_SHOW, S_WAIT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    row_s1_q, row_s2_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]    rand_q, rand_d;
  logic [2:0]    key_col_q, key_col_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [SW-1:0] show_cnt_q, show_cnt_d;
  logic [2:0]    user_sel_q, user_sel_d;
  logic [2:0]    cpu_sel_q, cpu_sel_d;
  logic [1:0]    result_q, result_d;
  logic          rv_q, rv_d;
  logic [3:0]    user_score_q, user_score_d;
  logic [3:0]    cpu_score_q, cpu_score_d;
  logic          over_q, over_d;
  logic          winner_q, winner_d;
  logic          tick;
  logic [3:0]    krow;

  function automatic logic [2:0] rand_onehot(input logic [1:0] r);
    case (r)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // 01 user wins, 10 cpu wins, 11 draw
  function automatic logic [1:0] judge(input logic [2:0] u, input logic [2:0] c);
    if (u == c) return 2'b11;
    if ((u == 3'b001 && c == 3'b010) ||
        (u == 3'b010 && c == 3'b100) ||
        (u == 3'b100 && c == 3'b001)) return 2'b01;
    return 2'b10;
  endfunction

  assign krow = row_s2_q;
  assign tick = (tick_cnt_q == TICK_LAST);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      row_s1_q     <= '0;
      row_s2_q     <= '0;
      tick_cnt_q   <= '0;
      rand_q       <= 2'd1;
      key_col_q    <= '0;
      db_cnt_q     <= '0;
      show_cnt_q   <= '0;
      user_sel_q   <= '0;
      cpu_sel_q    <= '0;
      result_q     <= '0;
      rv_q         <= 1'b0;
      user_score_q <= '0;
      cpu_score_q  <= '0;
      over_q       <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_s1_q     <= key_row;
      row_s2_q     <= row_s1_q;
      tick_cnt_q   <= tick_cnt_d;
      rand_q       <= rand_d;
      key_col_q    <= key_col_d;
      db_cnt_q     <= db_cnt_d;
      show_cnt_q   <= show_cnt_d;
      user_sel_q   <= user_sel_d;
      cpu_sel_q    <= cpu_sel_d;
      result_q     <= result_d;
      rv_q         <= rv_d;
      user_score_q <= user_score_d;
      cpu_score_q  <= cpu_score_d;
      over_q       <= over_d;
      winner_q     <= winner_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick ? '0 : tick_cnt_q + TW'(1);
    rand_d       = (rand_q == 2'd3) ? 2'd1 : rand_q + 2'd1;
    key_col_d    = key_col_q;
    db_cnt_d     = db_cnt_q;
    show_cnt_d   = show_cnt_q;
    user_sel_d   = user_sel_q;
    cpu_sel_d    = cpu_sel_q;
    result_d     = result_q;
    rv_d         = 1'b0;
    user_score_d = user_score_q;
    cpu_score_d  = cpu_score_q;
    over_d       = over_q;
    winner_d     = winner_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SCAN;
          key_col_d = COL_ROCK;
        end
      end
      S_SCAN: begin
        if (tick) begin
          if (krow == 4'b0000) begin
            key_col_d = {key_col_q[1:0], key_col_q[2]};
          end else if (krow == 4'b0001) begin
            db_cnt_d = '0;
            state_d  = S_DEB;
          end
        end
      end
      S_DEB: begin
        // a bounce drops back to scanning without rotating on that tick
        if (tick) begin
          if (krow == 4'b0001) begin
            if (db_cnt_q == DB_LAST) begin
              user_sel_d = key_col_q;
              cpu_sel_d  = rand_onehot(rand_q);
              db_cnt_d   = '0;
              state_d    = S_JUDGE;
            end else begin
              db_cnt_d = db_cnt_q + DW'(1);
            end
          end else begin
            db_cnt_d = '0;
            state_d  = S_SCAN;
          end
        end
      end
      S_JUDGE: begin
        result_d   = judge(user_sel_q, cpu_sel_q);
        rv_d       = 1'b1;
        show_cnt_d = '0;
        state_d    = S_SHOW;
        if (result_d == 2'b01) user_score_d = user_score_q + 4'd1;
        if (result_d == 2'b10) cpu_score_d  = cpu_score_q + 4'd1;
      end
      S_SHOW: begin
        if (tick) begin
          if (show_cnt_q == SHOW_LAST) state_d = S_WAIT;
          else show_cnt_d = show_cnt_q + SW'(1);
        end
      end
      S_WAIT: begin
        if (tick && krow == 4'b0000) begin
          if (user_score_q == WIN || cpu_score_q == WIN) begin
            state_d   = S_DONE;
            key_col_d = '0;
            over_d    = 1'b1;
            winner_d  = (cpu_score_q == WIN);
          end else begin
            state_d   = S_SCAN;
            key_col_d = COL_ROCK;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          state_d      = S_SCAN;
          key_col_d    = COL_ROCK;
          user_score_d = '0;
          cpu_score_d  = '0;
          user_sel_d   = '0;
          cpu_sel_d    = '0;
          result_d     = '0;
          over_d       = 1'b0;
          winner_d     = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    key_col      = key_col_q;
    user_sel     = user_sel_q;
    cpu_sel      = cpu_sel_q;
    result       = result_q;
    result_valid = rv_q;
    user_score   = user_score_q;
    cpu_score    = cpu_score_q;
    match_over   = over_q;
    match_winner = winner_q;
  end

endmodule
